nios_system_myip_cpu_cpu_div_cell: RTL and testbench

- Iterative integer divider for the Nios II CPU execute/memory path; it is the inverse companion of the multiplier cell.
- Operands are sourced from the same E_src1/E_src2 operand buses.
- Computes the quotient and remainder for div (signed) and divu (unsigned) using a radix-2 restoring algorithm, one bit per clock.
- The CPU stalls on div_busy and captures results on the div_done pulse.

---
 rtl/nios_system_myip_cpu_cpu_div_cell.sv | 106 ++++++++++
 tb/tb_nios_system_myip_cpu_cpu_div_cell.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nios_system_myip_cpu_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu: one quotient bit per clock,
// with sign fix-up, divide-by-zero reporting and pipeline-flush abort.
module nios_system_myip_cpu_cpu_div_cell #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] E_src1,
  input  logic [DATA_WIDTH-1:0] E_src2,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic                  div_abort,
  output logic                  div_busy,
  output logic                  div_done,
  output logic [DATA_WIDTH-1:0] div_quot,
  output logic [DATA_WIDTH-1:0] div_rem,
  output logic                  div_by_zero
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
  state_t state, state_nxt;

  logic [W-1:0]         a_raw, b_raw, quot, rem, dvsr;
  logic                 sgn, neg_q, neg_r, dz;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W:0]           rem_sh, trial;

  // rem < dvsr always holds, so the shifted remainder fits in W+1 bits and
  // the MSB of the W+1 bit trial difference is the borrow.
  assign rem_sh   = {rem, quot[W-1]};
  assign trial    = rem_sh - {1'b0, dvsr};
  assign div_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (div_start) state_nxt = PREP;
      PREP: state_nxt = div_abort ? IDLE : ITER;
      ITER: if (div_abort)      state_nxt = IDLE;
            else if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_raw       <= '0;
      b_raw       <= '0;
      sgn         <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
      div_done    <= 1'b0;
      div_quot    <= '0;
      div_rem     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      div_done <= 1'b0;
      case (state)
        IDLE: if (div_start) begin
          a_raw <= E_src1;
          b_raw <= E_src2;
          sgn   <= div_signed;
        end
        PREP: begin
          quot  <= (sgn && a_raw[W-1]) ? -a_raw : a_raw;
          dvsr  <= (sgn && b_raw[W-1]) ? -b_raw : b_raw;
          neg_q <= sgn & (a_raw[W-1] ^ b_raw[W-1]);
          neg_r <= sgn & a_raw[W-1];
          dz    <= (b_raw == '0);
          rem   <= '0;
          cnt   <= '0;
        end
        ITER: begin
          if (!trial[W]) rem <= trial[W-1:0];
          else           rem <= rem_sh[W-1:0];
          quot <= {quot[W-2:0], ~trial[W]};
          cnt  <= cnt + 1'b1;
        end
        FIX: if (!div_abort) begin
          // Divide by zero reports the untouched dividend and skips sign fix.
          div_quot    <= dz ? '1 : (neg_q ? -quot : quot);
          div_rem     <= dz ? a_raw : (neg_r ? -rem : rem);
          div_by_zero <= dz;
          div_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_myip_cpu_cpu_div_cell.sv
// Scoreboard bench for the divider cell: driver pushes reference results,
// a negedge monitor pops and compares on every div_done.
module tb_nios_system_myip_cpu_cpu_div_cell;
  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] E_src1 = '0, E_src2 = '0;
  logic         div_start = 1'b0, div_signed = 1'b0, div_abort = 1'b0;
  logic         div_busy, div_done, div_by_zero;
  logic [W-1:0] div_quot, div_rem;

  nios_system_myip_cpu_cpu_div_cell #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .E_src1(E_src1), .E_src2(E_src2),
    .div_start(div_start), .div_signed(div_signed), .div_abort(div_abort),
    .div_busy(div_busy), .div_done(div_done), .div_quot(div_quot),
    .div_rem(div_rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] q, r;
    logic         z;
    int           due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0, passes = 0;
  logic [W-1:0] last_q = '0, last_r = '0;
  logic         last_z = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference: plain 64-bit integer division, truncating toward zero.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint na, nb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      na = s ? longint'($signed(a)) : longint'({32'b0, a});
      nb = s ? longint'($signed(b)) : longint'({32'b0, b});
      q = W'(na / nb);
      r = W'(na % nb);
      z = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && div_done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: div_done=1 with nothing outstanding, expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quot", div_quot, e.q);
        chk("rem", div_rem, e.r);
        chk("by_zero", div_by_zero, e.z);
        chk("latency", cyc, e.due);
        chk("busy_at_done", div_busy, 1'b0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit push, input bit with_abort);
    int n = 0;
    exp_t x;
    @(negedge clk);
    while (div_busy && n < 100) begin @(negedge clk); n++; end
    if (div_busy) begin
      checks++;
      $display("FAIL idle_timeout: busy=1 after 100 cycles, expected 0");
    end
    E_src1 = a; E_src2 = b; div_signed = s; div_start = 1'b1; div_abort = with_abort;
    @(posedge clk);
    #1;
    div_start = 1'b0; div_abort = 1'b0;
    E_src1 = $urandom; E_src2 = $urandom; div_signed = $urandom_range(0, 1);
    if (push) begin
      ref_div(a, b, s, x.q, x.r, x.z);
      x.due = cyc + LAT;
      sb.push_back(x);
      last_q = x.q; last_r = x.r; last_z = x.z;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    repeat (3) @(negedge clk);
    chk("reset_quot", div_quot, 0);
    chk("reset_rem", div_rem, 0);
    chk("reset_busy", div_busy, 0);
    chk("reset_done", div_done, 0);
    chk("reset_by_zero", div_by_zero, 0);
    reset_n = 1'b1;

    issue(100, 7, 1'b0, 1, 0);
    issue(-7, 2, 1'b1, 1, 0);
    issue(7, -2, 1'b1, 1, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 0);
    issue(32'hFFFF_FFFF, 1, 1'b0, 1, 0);
    issue(5, 0, 1'b0, 1, 0);
    issue(5, 0, 1'b1, 1, 1);   // abort together with start in IDLE: start wins
    drain();

    // Start while busy is ignored; next start lands in the done cycle.
    issue(100, 7, 1'b0, 1, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    E_src1 = 9; E_src2 = 3; div_signed = 1'b0; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    issue(9, 3, 1'b0, 1, 0);
    drain();

    // Abort mid-ITER: no done, outputs keep previous results.
    issue(1000, 3, 1'b0, 0, 0);
    repeat (14) @(posedge clk);
    @(negedge clk) div_abort = 1'b1;
    @(posedge clk);
    #1 div_abort = 1'b0;
    chk("abort_busy", div_busy, 0);
    chk("abort_quot_held", div_quot, last_q);
    chk("abort_rem_held", div_rem, last_r);
    chk("abort_by_zero_held", div_by_zero, last_z);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-ITER.
    issue(12345, 67, 1'b1, 0, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_quot", div_quot, 0);
    chk("async_rst_rem", div_rem, 0);
    chk("async_rst_by_zero", div_by_zero, 0);
    chk("async_rst_busy", div_busy, 0);
    chk("async_rst_done", div_done, 0);
    last_q = '0; last_r = '0; last_z = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = -W'($urandom_range(1, 15));
        3:       b = $urandom_range(0, 1) ? 32'h1 : 32'hFFFF_FFFF;
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(a, b, 1'($urandom_range(0, 1)), 1, 0);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
